// File: rtl/rng_share_arbiter.sv
// rtl/rng_share_arbiter.sv - round-robin sharing of one LCG generator among NUM_REQ burst requesters
module rng_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int LEN_W      = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*LEN_W-1:0]   req_len,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       gen_enable,
    input  logic [DATA_WIDTH-1:0]      gen_rnd,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [$clog2(NUM_REQ)-1:0] out_id,
    output logic                       out_last,
    output logic                       busy
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_OUT
    } state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] owner;
    logic [LEN_W:0]  remaining;

    logic            found;
    logic [ID_W-1:0] pick;
    logic [LEN_W-1:0] pick_len;
    logic [LEN_W:0]  start_len;

    // Search upward from ptr+1 with wrap; ptr itself is the last candidate,
    // so the previous owner only wins again when nobody else is asking.
    always_comb begin
        int idx;
        idx      = 0;
        found    = 1'b0;
        pick     = ptr;
        pick_len = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[ID_W'(idx)]) begin
                found    = 1'b1;
                pick     = ID_W'(idx);
                pick_len = req_len[idx*LEN_W +: LEN_W];
            end
        end
    end

    // A zero length still delivers one word.
    assign start_len = (pick_len == '0) ? (LEN_W+1)'(1) : {1'b0, pick_len};

    // gen_enable is registered on entry to ISSUE, so it is high for exactly
    // the ISSUE cycle and the generator word is ready during CAPTURE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ptr        <= ID_W'(NUM_REQ - 1);
            owner      <= '0;
            remaining  <= '0;
            gnt        <= '0;
            gen_enable <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_id     <= '0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            gen_enable <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        owner      <= pick;
                        remaining  <= start_len;
                        gnt        <= NUM_REQ'(1) << pick;
                        gen_enable <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    out_data  <= gen_rnd;
                    out_id    <= owner;
                    out_last  <= (remaining == (LEN_W+1)'(1));
                    out_valid <= 1'b1;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        remaining <= remaining - (LEN_W+1)'(1);
                        // Owner dropping req mid-burst truncates silently.
                        if (out_last || !req[owner]) begin
                            gnt   <= '0;
                            ptr   <= owner;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            gen_enable <= 1'b1;
                            state      <= S_ISSUE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rng_share_arbiter.sv
// tb/tb_rng_share_arbiter.sv - directed self-checking bench for rng_share_arbiter
module tb_rng_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_len;
    logic [3:0]  gnt;
    logic        gen_enable;
    logic [31:0] gen_rnd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_id;
    logic        out_last;
    logic        busy;

    logic [31:0] lcg_state;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    int gnt_cnt = 0;

    logic [31:0] q_data[$];
    logic [1:0]  q_id[$];
    logic        q_last[$];

    logic        stall_prev = 1'b0;
    logic [34:0] held;

    rng_share_arbiter #(.DATA_WIDTH(32), .NUM_REQ(4), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len), .gnt(gnt),
        .gen_enable(gen_enable), .gen_rnd(gen_rnd), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // Generator model: first enabled word is the seed, then the LCG sequence.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcg_state <= 32'd123456;
            gen_rnd   <= 32'd0;
        end else if (gen_enable) begin
            gen_rnd   <= lcg_state;
            lcg_state <= lcg_state * 32'd1103515245 + 32'd12345;
        end
    end

    function automatic logic [31:0] lcg_next(input logic [31:0] x);
        return x * 32'd1103515245 + 32'd12345;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (gen_enable) en_cnt++;
            if (|gnt) gnt_cnt++;
            if (stall_prev && out_valid)
                check("stall_stable", {29'd0, out_data, out_id, out_last}, {29'd0, held});
            if (out_valid && out_ready) begin
                q_data.push_back(out_data);
                q_id.push_back(out_id);
                q_last.push_back(out_last);
            end
            stall_prev = out_valid && !out_ready;
            held       = {out_data, out_id, out_last};
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        q_data.delete();
        q_id.delete();
        q_last.delete();
        en_cnt  = 0;
        gnt_cnt = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        clear_log();
    endtask

    task automatic wait_words(input string tag, input int n, input int budget);
        int c = 0;
        while (q_data.size() < n && c < budget) begin
            tick();
            c++;
        end
        check(tag, q_data.size(), n);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int c = 0;
        while (!out_valid && c < budget) begin
            tick();
            c++;
        end
        check(tag, out_valid, 1);
    endtask

    initial begin
        logic [31:0] exp_d;

        req       = 4'b0000;
        req_len   = 32'd0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_gnt", gnt, 0);
        check("rst_en", gen_enable, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_id", out_id, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);

        // Round-robin from reset: requester 0 first
        do_reset();
        req_len   = {8'd1, 8'd1, 8'd1, 8'd1};
        req       = 4'b1111;
        out_ready = 1'b1;
        wait_words("rr_count", 5, 40);
        req = 4'b0000;
        repeat (4) tick();
        check("rr_total", q_data.size(), 5);
        exp_d = 32'd123456;
        for (int i = 0; i < 5 && i < q_data.size(); i++) begin
            check($sformatf("rr_id%0d", i), q_id[i], i % 4);
            check($sformatf("rr_last%0d", i), q_last[i], 1);
            check($sformatf("rr_data%0d", i), q_data[i], exp_d);
            exp_d = lcg_next(exp_d);
        end
        check("rr_en", en_cnt, 5);

        // Single requester, length 2, with latency checks
        do_reset();
        req_len = {8'd0, 8'd0, 8'd0, 8'd2};
        req     = 4'b0001;
        tick();
        check("s_gnt", gnt, 4'b0001);
        check("s_busy", busy, 1);
        check("s_en_issue", gen_enable, 1);
        tick();
        check("s_en_capture", gen_enable, 0);
        check("s_valid_capture", out_valid, 0);
        tick();
        check("s_valid_out", out_valid, 1);
        check("s_data0_early", out_data, 32'd123456);
        wait_words("s_count", 2, 20);
        req = 4'b0000;
        repeat (4) tick();
        check("s_total", q_data.size(), 2);
        if (q_data.size() == 2) begin
            check("s_data0", q_data[0], 32'd123456);
            check("s_data1", q_data[1], 32'd3510437241);
            check("s_id0", q_id[0], 0);
            check("s_id1", q_id[1], 0);
            check("s_last0", q_last[0], 0);
            check("s_last1", q_last[1], 1);
        end
        check("s_en", en_cnt, 2);
        check("s_gnt_cycles", gnt_cnt, 6);
        check("s_idle_gnt", gnt, 0);

        // Length 0 on requester 2
        do_reset();
        req_len = {8'd0, 8'd0, 8'd0, 8'd0};
        req     = 4'b0100;
        wait_words("z_count", 1, 20);
        req = 4'b0000;
        repeat (6) tick();
        check("z_total", q_data.size(), 1);
        if (q_data.size() == 1) begin
            check("z_id", q_id[0], 2);
            check("z_last", q_last[0], 1);
        end
        check("z_en", en_cnt, 1);

        // Back-pressure: 5 stalled cycles per word
        do_reset();
        req_len   = {8'd0, 8'd0, 8'd0, 8'd3};
        req       = 4'b0001;
        out_ready = 1'b0;
        for (int w = 0; w < 3; w++) begin
            wait_valid($sformatf("bp_valid%0d", w), 20);
            repeat (5) tick();
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            if (w == 2) req = 4'b0000;
        end
        repeat (6) tick();
        check("bp_total", q_data.size(), 3);
        if (q_data.size() == 3) begin
            check("bp_last0", q_last[0], 0);
            check("bp_last1", q_last[1], 0);
            check("bp_last2", q_last[2], 1);
            check("bp_data2", q_data[2], lcg_next(32'd3510437241));
        end
        check("bp_en", en_cnt, 3);

        // Abort: requester 1 drops req before the 2nd word is accepted
        do_reset();
        req_len   = {8'd0, 8'd0, 8'd5, 8'd0};
        req       = 4'b0010;
        out_ready = 1'b1;
        wait_words("ab_first", 1, 20);
        req = 4'b0000;
        wait_words("ab_second", 2, 20);
        repeat (6) tick();
        check("ab_total", q_data.size(), 2);
        if (q_data.size() == 2) begin
            check("ab_last0", q_last[0], 0);
            check("ab_last1", q_last[1], 0);
            check("ab_id1", q_id[1], 1);
        end
        check("ab_en", en_cnt, 2);
        check("ab_busy", busy, 0);
        check("ab_gnt", gnt, 0);

        // Reset mid-burst: ptr=1 so requester 2 wins before reset, 0 after
        clear_log();
        req_len   = {8'd3, 8'd3, 8'd3, 8'd3};
        req       = 4'b0101;
        out_ready = 1'b0;
        wait_valid("mr_valid", 20);
        check("mr_owner_pre", out_id, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_gnt", gnt, 0);
        check("mr_valid_rst", out_valid, 0);
        check("mr_data", out_data, 0);
        check("mr_id", out_id, 0);
        check("mr_last", out_last, 0);
        check("mr_busy", busy, 0);
        check("mr_en", gen_enable, 0);
        #1;
        rst_n = 1'b1;
        clear_log();
        out_ready = 1'b1;
        wait_words("mr_first", 1, 20);
        if (q_data.size() >= 1) begin
            check("mr_owner_post", q_id[0], 0);
            check("mr_data_post", q_data[0], 32'd123456);
        end
        req = 4'b0000;
        repeat (12) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
